// File: rtl/peak_pkg.sv
// Shared widths, matrix size and FSM encoding for the peak finder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package peak_pkg;

    localparam int ROW_W    = 5;
    localparam int COL_W    = 5;
    localparam int DATA_W   = 8;
    localparam int MAT_SIZE = 1024;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/scan_addr_gen.sv
// Raster-order BRAM address generator plus a one-cycle delayed row/col tag aligned to read data.
// Latency: first address one cycle after scan_en rises; tag trails the address by one cycle.
// Backpressure: none; issues one address per cycle until the last matrix address.
module scan_addr_gen #(
    parameter int ROW_W = peak_pkg::ROW_W,
    parameter int COL_W = peak_pkg::COL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scan_en,
    output logic                   rd_en,
    output logic [ROW_W+COL_W-1:0] rd_addr,
    output logic                   last_issued,
    output logic                   smp_vld,
    output logic                   smp_first,
    output logic                   smp_last,
    output logic [ROW_W-1:0]       smp_row,
    output logic [COL_W-1:0]       smp_col
);
    import peak_pkg::*;

    localparam int AW = ROW_W + COL_W;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAT_SIZE - 1);

    logic          rd_en_q,     rd_en_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic          smp_vld_q,   smp_vld_d;
    logic          smp_first_q, smp_first_d;
    logic          smp_last_q,  smp_last_d;
    logic [ROW_W-1:0] smp_row_q, smp_row_d;
    logic [COL_W-1:0] smp_col_q, smp_col_d;
    logic          last_hit;

    always_comb begin
        last_hit = rd_en_q && (addr_q == LAST_ADDR);
        // The counter parks on the last address; it never wraps into a fresh read.
        rd_en_d  = scan_en && !last_hit;
        addr_d   = addr_q;
        if (scan_en && !rd_en_q) begin
            addr_d = '0;
        end else if (rd_en_q && !last_hit) begin
            addr_d = addr_q + AW'(1);
        end
        smp_vld_d   = rd_en_q;
        smp_first_d = rd_en_q && (addr_q == '0);
        smp_last_d  = last_hit;
        smp_row_d   = addr_q[AW-1:COL_W];
        smp_col_d   = addr_q[COL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            smp_vld_q   <= 1'b0;
            smp_first_q <= 1'b0;
            smp_last_q  <= 1'b0;
            smp_row_q   <= '0;
            smp_col_q   <= '0;
        end else begin
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            smp_vld_q   <= smp_vld_d;
            smp_first_q <= smp_first_d;
            smp_last_q  <= smp_last_d;
            smp_row_q   <= smp_row_d;
            smp_col_q   <= smp_col_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = addr_q;
    assign last_issued = last_hit;
    assign smp_vld     = smp_vld_q;
    assign smp_first   = smp_first_q;
    assign smp_last    = smp_last_q;
    assign smp_row     = smp_row_q;
    assign smp_col     = smp_col_q;

endmodule

// File: rtl/peak_finder.sv
// Scans a 32x32 BRAM matrix in raster order and reports the first maximum and its row/col.
// Latency: done and results 1026 cycles after the accepted scan_start rising edge.
// Backpressure: none; scan_start edges are ignored unless idle.
module peak_finder #(
    parameter int ROW_W  = peak_pkg::ROW_W,
    parameter int COL_W  = peak_pkg::COL_W,
    parameter int DATA_W = peak_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scan_start,
    output logic                   bram_rd_en,
    output logic [ROW_W+COL_W-1:0] bram_rd_addr,
    input  logic [DATA_W-1:0]      bram_rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   peak_valid,
    output logic [DATA_W-1:0]      peak_value,
    output logic [ROW_W-1:0]       peak_row,
    output logic [COL_W-1:0]       peak_col
);
    import peak_pkg::*;

    logic [1:0]        state_q,      state_d;
    logic              start_d1_q,   start_d1_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              valid_q,      valid_d;
    logic [DATA_W-1:0] max_q,        max_d;
    logic [ROW_W-1:0]  max_row_q,    max_row_d;
    logic [COL_W-1:0]  max_col_q,    max_col_d;
    logic [DATA_W-1:0] peak_value_q, peak_value_d;
    logic [ROW_W-1:0]  peak_row_q,   peak_row_d;
    logic [COL_W-1:0]  peak_col_q,   peak_col_d;

    logic              scan_en;
    logic              last_issued;
    logic              smp_vld;
    logic              smp_first;
    logic              smp_last;
    logic [ROW_W-1:0]  smp_row;
    logic [COL_W-1:0]  smp_col;

    logic              start_req;
    logic              capture_last;
    logic              take_new;
    logic [DATA_W-1:0] cand_value;
    logic [ROW_W-1:0]  cand_row;
    logic [COL_W-1:0]  cand_col;

    assign scan_en = (state_q == ST_SCAN);

    scan_addr_gen #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
        .rd_en       (bram_rd_en),
        .rd_addr     (bram_rd_addr),
        .last_issued (last_issued),
        .smp_vld     (smp_vld),
        .smp_first   (smp_first),
        .smp_last    (smp_last),
        .smp_row     (smp_row),
        .smp_col     (smp_col)
    );

    // Strict greater-than keeps the earliest raster position on ties.
    always_comb begin
        start_req    = scan_start && !start_d1_q && (state_q == ST_IDLE);
        capture_last = (state_q == ST_DRAIN) && smp_vld && smp_last;
        take_new     = smp_vld && (smp_first || (bram_rd_data > max_q));
        cand_value   = take_new ? bram_rd_data : max_q;
        cand_row     = take_new ? smp_row : max_row_q;
        cand_col     = take_new ? smp_col : max_col_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_req)    state_d = ST_SCAN;
            ST_SCAN:  if (last_issued)  state_d = ST_DRAIN;
            ST_DRAIN: if (capture_last) state_d = ST_DONE;
            ST_DONE:                    state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // The final sample is folded straight into the result registers so done lands on the capture edge.
    always_comb begin
        start_d1_d   = scan_start;
        busy_d       = busy_q;
        done_d       = capture_last;
        valid_d      = valid_q;
        max_d        = cand_value;
        max_row_d    = cand_row;
        max_col_d    = cand_col;
        peak_value_d = peak_value_q;
        peak_row_d   = peak_row_q;
        peak_col_d   = peak_col_q;
        if (state_q == ST_SCAN) begin
            busy_d  = 1'b1;
            valid_d = 1'b0;
        end
        if (capture_last) begin
            busy_d       = 1'b0;
            valid_d      = 1'b1;
            peak_value_d = cand_value;
            peak_row_d   = cand_row;
            peak_col_d   = cand_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_d1_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            max_q        <= '0;
            max_row_q    <= '0;
            max_col_q    <= '0;
            peak_value_q <= '0;
            peak_row_q   <= '0;
            peak_col_q   <= '0;
        end else begin
            state_q      <= state_d;
            start_d1_q   <= start_d1_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            max_q        <= max_d;
            max_row_q    <= max_row_d;
            max_col_q    <= max_col_d;
            peak_value_q <= peak_value_d;
            peak_row_q   <= peak_row_d;
            peak_col_q   <= peak_col_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign peak_valid = valid_q;
    assign peak_value = peak_value_q;
    assign peak_row   = peak_row_q;
    assign peak_col   = peak_col_q;

endmodule

// File: tb/tb_peak_finder.sv
// Bench for peak_finder: BRAM model, raster-order reference model and result scoreboard.
// Latency and address-stream properties are tracked by a negedge monitor.
// Inputs change #1 after posedge; outputs are sampled at the same point.
module tb_peak_finder;

    typedef struct packed {
        logic [7:0] v;
        logic [4:0] r;
        logic [4:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_start;
    logic       bram_rd_en;
    logic [9:0] bram_rd_addr;
    logic [7:0] bram_rd_data = 8'h00;
    logic       busy;
    logic       done;
    logic       peak_valid;
    logic [7:0] peak_value;
    logic [4:0] peak_row;
    logic [4:0] peak_col;

    logic [7:0] mem [0:1023];
    exp_t       sb [$];

    int total = 0;
    int bad   = 0;

    int         done_cnt = 0;
    int         addr_err = 0;
    int         run_len  = 0;
    int         last_run = 0;
    logic       prev_en  = 1'b0;
    logic [9:0] exp_addr = '0;

    logic       busy_k1, en_k1, pv_k1;
    logic [9:0] addr_k1;

    always #5 clk = ~clk;

    peak_finder dut (
        .clk          (clk),
        .rst          (rst),
        .scan_start   (scan_start),
        .bram_rd_en   (bram_rd_en),
        .bram_rd_addr (bram_rd_addr),
        .bram_rd_data (bram_rd_data),
        .busy         (busy),
        .done         (done),
        .peak_valid   (peak_valid),
        .peak_value   (peak_value),
        .peak_row     (peak_row),
        .peak_col     (peak_col)
    );

    always @(posedge clk) begin
        if (bram_rd_en === 1'b1) bram_rd_data <= mem[bram_rd_addr];
    end

    always @(negedge clk) begin
        if (bram_rd_en === 1'b1) begin
            if (!prev_en) begin
                exp_addr = '0;
                run_len  = 0;
            end
            if (bram_rd_addr !== exp_addr) addr_err++;
            exp_addr = exp_addr + 10'd1;
            run_len++;
        end else if (prev_en) begin
            last_run = run_len;
        end
        prev_en = (bram_rd_en === 1'b1);
        if (done === 1'b1) done_cnt++;
    end

    function automatic exp_t model_peak();
        exp_t e;
        e.v = mem[0];
        e.r = 5'd0;
        e.c = 5'd0;
        for (int a = 1; a < 1024; a++) begin
            if (mem[a] > e.v) begin
                e.v = mem[a];
                e.r = 5'(a >> 5);
                e.c = 5'(a & 31);
            end
        end
        return e;
    endfunction

    task automatic fill(input logic [7:0] val);
        for (int a = 0; a < 1024; a++) mem[a] = val;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Caller has set scan_start so that the next posedge is the request edge N.
    task automatic wait_done(input int drop_at, input int retrig_at, output int lat);
        lat = -1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 1200; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                busy_k1 = busy;
                en_k1   = bram_rd_en;
                addr_k1 = bram_rd_addr;
                pv_k1   = peak_valid;
            end
            if (k == drop_at)   scan_start = 1'b0;
            if (k == retrig_at) scan_start = 1'b1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        scan_start = 1'b0;
        idle(3);
        total++;
        if ({busy, done, peak_valid, bram_rd_en} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got busy/done/valid/en=%b want 0000", {busy, done, peak_valid, bram_rd_en});
        end
        total++;
        if ({bram_rd_addr, peak_value, peak_row, peak_col} !== 28'h0) begin
            bad++;
            $display("FAIL reset_data: got addr=%0d val=%h row=%0d col=%0d want all 0", bram_rd_addr, peak_value, peak_row, peak_col);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_ramp();
        int   lat;
        int   d0;
        int   e0;
        exp_t e;
        for (int a = 0; a < 1024; a++) mem[a] = 8'(a & 8'hFF);
        mem[17*32 + 9] = 8'hC8;
        sb.push_back(model_peak());
        d0 = done_cnt;
        e0 = addr_err;
        scan_start = 1'b1;
        wait_done(5, -1, lat);
        scan_start = 1'b0;
        total++;
        if (lat !== 1026) begin
            bad++;
            $display("FAIL ramp_latency: got %0d want 1026", lat);
        end
        total++;
        if ({busy_k1, en_k1, addr_k1, pv_k1} !== {1'b1, 1'b1, 10'd0, 1'b0}) begin
            bad++;
            $display("FAIL ramp_first_cycle: got busy=%b en=%b addr=%0d valid=%b want 1 1 0 0", busy_k1, en_k1, addr_k1, pv_k1);
        end
        e = sb.pop_front();
        total++;
        if ({peak_value, peak_row, peak_col} !== {e.v, e.r, e.c} || e.v !== 8'hFF || e.r !== 5'd7 || e.c !== 5'd31) begin
            bad++;
            $display("FAIL ramp_peak: got %h r%0d c%0d want %h r%0d c%0d (ff r7 c31)", peak_value, peak_row, peak_col, e.v, e.r, e.c);
        end
        total++;
        if ({busy, peak_valid} !== 2'b01) begin
            bad++;
            $display("FAIL ramp_flags_at_done: got busy=%b valid=%b want 0 1", busy, peak_valid);
        end
        total++;
        if (last_run !== 1024 || addr_err !== e0) begin
            bad++;
            $display("FAIL ramp_addr_stream: got run=%0d addr_err=%0d want 1024 %0d", last_run, addr_err, e0);
        end
        idle(1);
        total++;
        if (done !== 1'b0 || done_cnt !== d0 + 1) begin
            bad++;
            $display("FAIL ramp_done_pulse: got done=%b count=%0d want 0 %0d", done, done_cnt, d0 + 1);
        end
        mem[0] = 8'hFF;
        idle(10);
        total++;
        if ({peak_value, peak_row, peak_col, peak_valid} !== {e.v, e.r, e.c, 1'b1}) begin
            bad++;
            $display("FAIL ramp_hold: got %h r%0d c%0d v%b want %h r%0d c%0d v1", peak_value, peak_row, peak_col, peak_valid, e.v, e.r, e.c);
        end
    endtask

    task automatic test_all_zero();
        int   lat;
        exp_t e;
        fill(8'h00);
        sb.push_back(model_peak());
        scan_start = 1'b1;
        wait_done(3, -1, lat);
        scan_start = 1'b0;
        total++;
        if (pv_k1 !== 1'b0) begin
            bad++;
            $display("FAIL zero_valid_clear: got valid=%b at N+1 want 0", pv_k1);
        end
        e = sb.pop_front();
        total++;
        if ({lat == 1026, peak_value, peak_row, peak_col, peak_valid} !== {1'b1, e.v, e.r, e.c, 1'b1}) begin
            bad++;
            $display("FAIL zero_peak: got lat=%0d %h r%0d c%0d v%b want 1026 %h r%0d c%0d v1", lat, peak_value, peak_row, peak_col, peak_valid, e.v, e.r, e.c);
        end
        idle(2);
    endtask

    task automatic test_last_addr();
        int   lat;
        exp_t e;
        fill(8'h00);
        mem[1023] = 8'h80;
        sb.push_back(model_peak());
        scan_start = 1'b1;
        wait_done(4, -1, lat);
        scan_start = 1'b0;
        e = sb.pop_front();
        total++;
        if ({peak_value, peak_row, peak_col} !== {e.v, e.r, e.c} || lat !== 1026) begin
            bad++;
            $display("FAIL last_addr_peak: got %h r%0d c%0d lat=%0d want %h r%0d c%0d lat=1026", peak_value, peak_row, peak_col, lat, e.v, e.r, e.c);
        end
        total++;
        if (last_run !== 1024) begin
            bad++;
            $display("FAIL last_addr_rd_en_len: got %0d want 1024", last_run);
        end
        idle(2);
    endtask

    task automatic test_tie();
        int   lat;
        exp_t e;
        fill(8'h10);
        mem[3*32 + 4]  = 8'h55;
        mem[20*32 + 1] = 8'h55;
        sb.push_back(model_peak());
        scan_start = 1'b1;
        wait_done(2, -1, lat);
        scan_start = 1'b0;
        e = sb.pop_front();
        total++;
        if ({peak_value, peak_row, peak_col} !== {e.v, e.r, e.c} || e.r !== 5'd3 || e.c !== 5'd4) begin
            bad++;
            $display("FAIL tie_first: got %h r%0d c%0d want %h r%0d c%0d (55 r3 c4)", peak_value, peak_row, peak_col, e.v, e.r, e.c);
        end
        idle(2);
    endtask

    task automatic test_retrigger();
        int   lat;
        int   d0;
        exp_t e;
        for (int a = 0; a < 1024; a++) mem[a] = 8'(255 - (a & 8'hFF));
        mem[600] = 8'hFF;
        sb.push_back(model_peak());
        d0 = done_cnt;
        scan_start = 1'b1;
        wait_done(10, 499, lat);
        e = sb.pop_front();
        total++;
        if (lat !== 1026) begin
            bad++;
            $display("FAIL retrig_latency: got %0d want 1026", lat);
        end
        total++;
        if ({peak_value, peak_row, peak_col} !== {e.v, e.r, e.c}) begin
            bad++;
            $display("FAIL retrig_peak: got %h r%0d c%0d want %h r%0d c%0d", peak_value, peak_row, peak_col, e.v, e.r, e.c);
        end
        idle(5);
        total++;
        if ({busy, bram_rd_en} !== 2'b00 || done_cnt !== d0 + 1 || last_run !== 1024) begin
            bad++;
            $display("FAIL retrig_no_restart: got busy=%b en=%b dones=%0d run=%0d want 0 0 %0d 1024", busy, bram_rd_en, done_cnt - d0, last_run, 1);
        end
        scan_start = 1'b0;
        idle(2);
    endtask

    task automatic test_reset_abort();
        int   lat;
        int   d0;
        exp_t e;
        fill(8'h22);
        mem[100] = 8'h99;
        sb.push_back(model_peak());
        scan_start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) scan_start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        d0 = done_cnt;
        total++;
        if ({busy, done, peak_valid, bram_rd_en, bram_rd_addr, peak_value, peak_row, peak_col} !== 32'h0) begin
            bad++;
            $display("FAIL abort_outputs: got busy=%b done=%b v=%b en=%b addr=%0d %h r%0d c%0d want all 0", busy, done, peak_valid, bram_rd_en, bram_rd_addr, peak_value, peak_row, peak_col);
        end
        idle(2);
        rst = 1'b0;
        idle(1100);
        total++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: got dones=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
        fill(8'h33);
        mem[12*32 + 5] = 8'hEE;
        sb.push_back(model_peak());
        scan_start = 1'b1;
        wait_done(3, -1, lat);
        scan_start = 1'b0;
        e = sb.pop_front();
        total++;
        if ({lat == 1026, peak_value, peak_row, peak_col, peak_valid} !== {1'b1, e.v, e.r, e.c, 1'b1}) begin
            bad++;
            $display("FAIL abort_rescan: got lat=%0d %h r%0d c%0d v%b want 1026 %h r%0d c%0d v1", lat, peak_value, peak_row, peak_col, peak_valid, e.v, e.r, e.c);
        end
        idle(2);
    endtask

    task automatic test_start_held_reset();
        int   lat;
        exp_t e;
        fill(8'h01);
        mem[511] = 8'h7F;
        rst = 1'b1;
        scan_start = 1'b1;
        idle(3);
        rst = 1'b0;
        sb.push_back(model_peak());
        wait_done(20, -1, lat);
        scan_start = 1'b0;
        e = sb.pop_front();
        total++;
        if ({lat == 1026, peak_value, peak_row, peak_col} !== {1'b1, e.v, e.r, e.c}) begin
            bad++;
            $display("FAIL held_start_rescan: got lat=%0d %h r%0d c%0d want 1026 %h r%0d c%0d", lat, peak_value, peak_row, peak_col, e.v, e.r, e.c);
        end
        idle(2);
    endtask

    initial begin
        rst = 1'b1;
        scan_start = 1'b0;
        fill(8'h00);
        test_reset();
        test_ramp();
        test_all_zero();
        test_last_addr();
        test_tie();
        test_retrigger();
        test_reset_abort();
        test_start_held_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
